bcd_to_bin: RTL and testbench

// - Sequential BCD-to-binary decoder: converts a packed DIGITS-digit BCD word
//   (e.g. {ten_digit, unit_digit} from the two-digit BCD counter) into plain binary.
// - Reverse double-dabble, one bit per clock; start/busy/done handshake.
// - Sits downstream of the BCD counters and feeds the binary datapath (ALU, compare logic).

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_adjust.sv | 18 +
 rtl/bcd_to_bin.sv | 116 +++++++++++
 tb/tb_bcd_to_bin.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, digit limit, converter state encoding
// and a nibble validity helper.
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

   // Reverse double-dabble correction: a nibble that reaches 8 after a right
   // shift held 16+ before it, so it must lose 3 to stay a decimal weight.
   localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
   localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_SUB    = 4'd3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } bcd_state_t;

   function automatic logic bcd_valid(input logic [BCD_DIGIT_W-1:0] nibble);
      return nibble <= BCD_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double-dabble: subtract 3 from a nibble
// that is 8 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   // Conditional -3 correction.
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= BCD_ADJ_THRESH) begin
         digit_o = digit_i - BCD_ADJ_SUB;
      end
   end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one result bit
// per clock, with a start/busy/done handshake.
module bcd_to_bin
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = 7
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [DIGITS*BCD_DIGIT_W-1:0] bcd_in,
   output logic                          busy,
   output logic                          done,
   output logic [BIN_W-1:0]              bin_out,
   output logic                          err
);

   localparam int unsigned BCD_W = DIGITS * BCD_DIGIT_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   bcd_state_t         state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_out_q, bin_out_d;
   logic               err_q, err_d;

   logic [BCD_W+BIN_W-1:0] shifted;
   logic [BCD_W-1:0]       bcd_adj;
   logic                   in_ok;

   assign shifted = {bcd_q, bin_q} >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_i (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Flag the incoming word as valid only if every nibble is a decimal digit.
   always_comb begin
      in_ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!bcd_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
            in_ok = 1'b0;
         end
      end
   end

   // Next-state logic; DONE accepts start exactly like IDLE for back-to-back use.
   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      bin_d     = bin_q;
      cnt_d     = cnt_q;
      bin_out_d = bin_out_q;
      err_d     = err_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               bcd_d = bcd_in;
               bin_d = '0;
               cnt_d = '0;
               if (!in_ok) begin
                  state_d   = StDone;
                  err_d     = 1'b1;
                  bin_out_d = '0;
               end else begin
                  state_d = StShift;
                  err_d   = 1'b0;
               end
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StShift: begin
            bcd_d = bcd_adj;
            bin_d = shifted[BIN_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d   = StDone;
               bin_out_d = shifted[BIN_W-1:0];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         bcd_q     <= '0;
         bin_q     <= '0;
         cnt_q     <= '0;
         bin_out_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         bin_q     <= bin_d;
         cnt_q     <= cnt_d;
         bin_out_q <= bin_out_d;
         err_q     <= err_d;
      end
   end

   assign busy    = (state_q == StShift);
   assign done    = (state_q == StDone);
   assign bin_out = bin_out_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin (DIGITS=2, BIN_W=7) against a decimal
// arithmetic reference model.
module tb_bcd_to_bin;

   localparam int unsigned DIGITS = 2;
   localparam int unsigned BIN_W  = 7;
   localparam int LAT_OK  = BIN_W + 1;
   localparam int LAT_ERR = 1;

   logic             clk;
   logic             reset;
   logic             start;
   logic [7:0]       bcd_in;
   logic             busy;
   logic             done;
   logic [BIN_W-1:0] bin_out;
   logic             err;

   int n_checks = 0;
   int n_errors = 0;

   bcd_to_bin #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: decimal value of the two digits; any non-decimal nibble is an error.
   task automatic model(input logic [7:0] v, output int exp_bin, output bit exp_err);
      int tens, units;
      tens    = int'(v[7:4]);
      units   = int'(v[3:0]);
      exp_err = (tens > 9) || (units > 9);
      exp_bin = exp_err ? 0 : tens * 10 + units;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_bin"},  32'(bin_out), 0);
      check({tag, "_err"},  32'(err), 0);
   endtask

   // Called at the negedge of the first cycle after the accepting edge.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 1;
      busy_cycles = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", 0, 1);
      check("busy_done_excl", 32'(busy & done), 0);
   endtask

   task automatic check_result(input string tag, input logic [7:0] v, input int lat,
                               input int busy_cycles);
      int exp_bin;
      bit exp_err;
      model(v, exp_bin, exp_err);
      check({tag, "_lat"},  32'(lat), exp_err ? LAT_ERR : LAT_OK);
      check({tag, "_busy"}, 32'(busy_cycles), exp_err ? 0 : BIN_W);
      check({tag, "_bin"},  32'(bin_out), 32'(exp_bin));
      check({tag, "_err"},  32'(err), 32'(exp_err));
   endtask

   task automatic run_conv(input string tag, input logic [7:0] v);
      int lat, bc;
      @(negedge clk);
      bcd_in = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 8'hFF;
      wait_done(lat, bc);
      check_result(tag, v, lat, bc);
   endtask

   initial begin
      int lat, bc;
      logic [7:0] v;

      reset  = 1'b0;
      start  = 1'b0;
      bcd_in = 8'h00;
      repeat (2) @(negedge clk);
      check_idle_outputs("in_reset");
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("after_reset");

      run_conv("c42", 8'h42);
      run_conv("c99", 8'h99);
      run_conv("c00", 8'h00);
      run_conv("c5A", 8'h5A);
      run_conv("c37", 8'h37);
      run_conv("cA3", 8'hA3);

      // A start pulse while busy must be ignored.
      @(negedge clk);
      bcd_in = 8'h25;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (2) @(negedge clk);
      bcd_in = 8'h11;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      lat = 4;
      bc  = 3;
      while (!done && lat < 20) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      check_result("ignore_busy", 8'h25, lat, bc);
      @(negedge clk);
      check("ignore_no_requeue", 32'(busy | done), 0);

      // start held through DONE launches the next conversion with no idle gap.
      bcd_in = 8'h63;
      start  = 1'b1;
      @(negedge clk);
      wait_done(lat, bc);
      check_result("b2b_first", 8'h63, lat, bc);
      bcd_in = 8'h18;
      @(negedge clk);
      start = 1'b0;
      check("b2b_no_gap", 32'(busy), 1);
      wait_done(lat, bc);
      check_result("b2b_second", 8'h18, lat, bc);

      // Asynchronous reset in the middle of a conversion.
      run_conv("pre_abort", 8'h56);
      @(negedge clk);
      bcd_in = 8'h77;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_before", 32'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check_idle_outputs("abort_async");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done | busy), 0);
      end

      // Randomized words, including non-decimal nibbles.
      for (int i = 0; i < 40; i++) begin
         v = 8'($urandom_range(0, 255));
         run_conv("rand", v);
      end

      // Full decimal sweep, as produced by an upstream two-digit BCD counter.
      for (int t = 0; t < 10; t++) begin
         for (int u = 0; u < 10; u++) begin
            v = {4'(t), 4'(u)};
            run_conv("sweep", v);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
